// File: rtl/quad_dec_pkg.sv
// Shared types and Gray-phase helpers for the quadrature step decoder.
package quad_dec_pkg;

    typedef enum logic {PRIME, TRACK} qd_state_t;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    function automatic logic [1:0] next_fwd(input logic [1:0] phase);
        logic [1:0] succ;
        case (phase)
            PH0:     succ = PH1;
            PH1:     succ = PH2;
            PH2:     succ = PH3;
            default: succ = PH0;
        endcase
        return succ;
    endfunction

endpackage

// File: rtl/step_input_filter.sv
// One encoder channel: pin synchronizer followed by a persistence filter.
// i_load bypasses the filter so the decoder can prime on the current pin level.
module step_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    input  logic i_load,
    output logic o_synced,
    output logic o_filt
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_filt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_synced = w_synced;
    assign o_filt   = r_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    // Seeing CNT_LAST while still different means this is the FILTER_LEN-th cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
        end else if (w_synced == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B decoder: primes on the settled pin level, then turns filtered
// Gray-code transitions into up/down pulses and flags double-bit jumps.
module quadrature_step_decoder
    import quad_dec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             err_clr,
    output logic             up,
    output logic             down,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int PRIME_LEN = SYNC_STAGES + FILTER_LEN;
    localparam int PRIME_W   = $clog2(PRIME_LEN + 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_LEN - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    qd_state_t          r_state;
    qd_state_t          w_state_next;
    logic [PRIME_W-1:0] r_prime_cnt;
    logic [1:0]         r_prev;
    logic               r_up;
    logic               r_down;
    logic               r_err;
    logic [ERR_W-1:0]   r_err_count;

    logic       w_a_sync, w_b_sync, w_a_filt, w_b_filt;
    logic       w_load;
    logic [1:0] w_cur;
    logic [1:0] w_sync;
    logic       w_fwd, w_rev, w_ill;

    step_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .i_pin(a_in), .i_load(w_load),
        .o_synced(w_a_sync), .o_filt(w_a_filt)
    );

    step_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .i_pin(b_in), .i_load(w_load),
        .o_synced(w_b_sync), .o_filt(w_b_filt)
    );

    assign w_cur  = {w_a_filt, w_b_filt};
    assign w_sync = {w_a_sync, w_b_sync};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= PRIME;
            r_prime_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == PRIME) begin
                r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PRIME:   if (r_prime_cnt == PRIME_LAST) w_state_next = TRACK;
            default: w_state_next = TRACK;
        endcase
    end

    // A reverse step is one whose forward successor is the previous phase.
    always_comb begin
        w_load = (r_state == PRIME);
        w_fwd  = 1'b0;
        w_rev  = 1'b0;
        w_ill  = 1'b0;
        if (r_state == TRACK) begin
            w_fwd = (w_cur == next_fwd(r_prev));
            w_rev = (r_prev == next_fwd(w_cur));
            w_ill = ((w_cur ^ r_prev) == 2'b11);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= 2'b00;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_prev <= w_load ? w_sync : w_cur;
            r_up   <= en & w_fwd;
            r_down <= en & w_rev;
            r_err  <= en & w_ill;
            if (err_clr) begin
                r_err_count <= '0;
            end else if (en && w_ill && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign up        = r_up;
    assign down      = r_down;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench: the driver queues each expected pulse with its due cycle,
// and a negedge monitor compares outputs against the head of that queue.
module tb_quadrature_step_decoder;

    localparam logic [2:0] K_UP = 3'b100;
    localparam logic [2:0] K_DN = 3'b010;
    localparam logic [2:0] K_ER = 3'b001;
    localparam logic [2:0] K_NO = 3'b000;
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_in, b_in, en, err_clr;
    logic       up, down, err;
    logic [7:0] err_count;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_cnt = 8'd0;
    logic [7:0] sb_cnt = 8'd0;

    quadrature_step_decoder dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .en(en),
        .err_clr(err_clr), .up(up), .down(down), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Drive a new pin phase and queue the pulse it should produce LAT edges later.
    task automatic step(input logic [1:0] ph, input logic [2:0] kind, input int hold);
        exp_t e;
        {a_in, b_in} = ph;
        if (kind == K_ER) model_cnt = (model_cnt == 8'hFF) ? 8'hFF : model_cnt + 8'd1;
        if (kind != K_NO) begin
            e.cyc  = cyc + LAT;
            e.kind = kind;
            e.cnt  = model_cnt;
            sb_q.push_back(e);
            $display("step cycle=%0d phase=%b expect kind=%b at cycle %0d cnt=%0d",
                     cyc, ph, kind, e.cyc, e.cnt);
        end
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                check("pulse", {29'd0, up, down, err}, {29'd0, e.kind});
                sb_cnt = e.cnt;
            end else begin
                check("idle", {29'd0, up, down, err}, 32'd0);
            end
            check("err_count", {24'd0, err_count}, {24'd0, sb_cnt});
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1; a_in = 1'b1; b_in = 1'b1; en = 1'b1; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_up", {31'd0, up}, 32'd0);
        check("reset_down", {31'd0, down}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_cnt", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("prime_prev", {30'd0, dut.r_prev}, 32'd3);

        // Walk from 11 back to 00 forward, then a full forward and reverse cycle.
        step(2'b10, K_UP, 10);
        step(2'b00, K_UP, 10);
        step(2'b01, K_UP, 10);
        step(2'b11, K_UP, 10);
        step(2'b10, K_UP, 10);
        step(2'b00, K_UP, 10);
        step(2'b10, K_DN, 10);
        step(2'b11, K_DN, 10);
        step(2'b01, K_DN, 10);
        step(2'b00, K_DN, 10);

        // Short glitch on A must never reach the filtered level.
        a_in = 1'b1;
        repeat (3) @(negedge clk);
        a_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("glitch_filt_a", {31'd0, dut.w_a_filt}, 32'd0);
            @(negedge clk);
        end

        // Repeated illegal 00->11 jumps, returning to 00 through 10.
        for (int j = 0; j < 300; j++) begin
            step(2'b11, K_ER, 6);
            step(2'b10, K_UP, 6);
            step(2'b00, K_UP, 6);
        end

        // err_clr on the same edge as an err pulse wins over the increment.
        {a_in, b_in} = 2'b11;
        model_cnt = 8'd0;
        e.cyc = cyc + LAT; e.kind = K_ER; e.cnt = 8'd0;
        sb_q.push_back(e);
        $display("step cycle=%0d phase=11 expect err with err_clr at cycle %0d", cyc, e.cyc);
        repeat (LAT - 1) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        step(2'b10, K_UP, 6);
        step(2'b00, K_UP, 10);

        // Steps while disabled produce nothing, and nothing stale afterwards.
        en = 1'b0;
        step(2'b01, K_NO, 10);
        step(2'b11, K_NO, 10);
        en = 1'b1;
        step(2'b10, K_UP, 10);
        step(2'b00, K_UP, 10);

        // Asynchronous reset mid-operation clears outputs before any clock edge.
        step(2'b11, K_ER, 6);
        step(2'b10, K_UP, 6);
        step(2'b00, K_UP, 10);
        reset = 1'b1;
        #1;
        check("async_cnt", {24'd0, err_count}, 32'd0);
        check("async_pulses", {29'd0, up, down, err}, 32'd0);
        model_cnt = 8'd0;
        sb_cnt = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        step(2'b01, K_UP, 10);
        step(2'b00, K_DN, 10);

        repeat (5) @(negedge clk);
        check("queue_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
